// File: rtl/display_color_modulator.sv
// ---------------------------------------------------------------------------
// display_color_modulator
//
// Encodes CHANNELS parallel RGB pixels into one drive bit per colour
// component. Contains its own sub-frame sequencer. Two modulation schemes are
// supported:
//   - PWM: a threshold `cycle` runs 1..2^W-1. A component is lit while it is
//     >= cycle.
//   - BCM: a bit-plane index runs 0..W-1. The component's bit at that plane
//     drives the output. `weight` tells the scan driver how long to hold it.
// The mode request is only taken at frame boundaries, so a frame is never
// built from both schemes.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   mode       requested mode (0 = PWM, 1 = BCM), taken at frame boundaries
//   advance    strobe from the scan driver: current sub-frame finished
//   in_valid   in_pixel carries a pixel this cycle
//   in_pixel   CHANNELS x {R,G,B} components, channel c at [c*3*W +: 3*W]
//   out_valid  out_rgb was loaded on this edge
//   out_rgb    per channel {R,G,B} drive bits, channel c at [c*3 +: 3]
//   cycle      current PWM threshold (held at 1 in BCM)
//   plane      current BCM bit-plane (held at 0 in PWM)
//   weight     relative sub-frame duration (1<<plane in BCM, 1 in PWM)
//   wrap       one-cycle pulse on the edge that completes a frame
// ---------------------------------------------------------------------------
module display_color_modulator #(
  parameter int CYCLEWIDTH = 8,
  parameter int CHANNELS   = 2,
  parameter int PLANEWIDTH = (CYCLEWIDTH > 1) ? $clog2(CYCLEWIDTH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode,
  input  logic                             advance,
  input  logic                             in_valid,
  input  logic [CHANNELS*3*CYCLEWIDTH-1:0] in_pixel,
  output logic                             out_valid,
  output logic [CHANNELS*3-1:0]            out_rgb,
  output logic [CYCLEWIDTH-1:0]            cycle,
  output logic [PLANEWIDTH-1:0]            plane,
  output logic [CYCLEWIDTH-1:0]            weight,
  output logic                             wrap
);

  localparam logic [CYCLEWIDTH-1:0] CYCLE_LAST = '1;
  localparam logic [CYCLEWIDTH-1:0] CYCLE_ONE  = CYCLEWIDTH'(1);
  localparam logic [PLANEWIDTH-1:0] PLANE_LAST = PLANEWIDTH'(CYCLEWIDTH - 1);

  logic                  mode_q;
  logic                  frame_end;
  logic [PLANEWIDTH-1:0] plane_next;
  logic [CYCLEWIDTH-1:0] cycle_next;
  logic [CHANNELS*3-1:0] enc;
  logic [CYCLEWIDTH-1:0] comp;

  // Only the counter that belongs to the active mode can end a frame.
  assign frame_end  = advance && (mode_q ? (plane == PLANE_LAST) : (cycle == CYCLE_LAST));
  assign plane_next = plane + 1'b1;
  assign cycle_next = cycle + 1'b1;

  // Encode every component against the pre-advance sequencer state. cycle
  // never reads 0, so the explicit zero test only guards against that
  // invariant ever being broken.
  always_comb begin
    enc  = '0;
    comp = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < 3; k++) begin
        comp = in_pixel[(c*3 + k)*CYCLEWIDTH +: CYCLEWIDTH];
        if (mode_q) begin
          enc[c*3 + k] = comp[plane];
        end else begin
          enc[c*3 + k] = (comp >= cycle) && (comp != '0);
        end
      end
    end
  end

  // Sequencer and output register. On a frame-completing advance both
  // counters return to their start values and the new mode is adopted, so
  // weight can go straight back to 1 regardless of the mode chosen.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_rgb   <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      cycle     <= CYCLE_ONE;
      plane     <= '0;
      weight    <= CYCLE_ONE;
      mode_q    <= mode;
    end else begin
      wrap <= 1'b0;

      if (frame_end) begin
        wrap   <= 1'b1;
        mode_q <= mode;
        cycle  <= CYCLE_ONE;
        plane  <= '0;
        weight <= CYCLE_ONE;
      end else if (advance) begin
        if (mode_q) begin
          plane  <= plane_next;
          weight <= CYCLE_ONE << plane_next;
        end else begin
          cycle  <= cycle_next;
          weight <= CYCLE_ONE;
        end
      end

      if (in_valid) begin
        out_valid <= 1'b1;
        out_rgb   <= enc;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_color_modulator.sv
// ---------------------------------------------------------------------------
// tb_display_color_modulator
//
// Self-checking bench for display_color_modulator (CYCLEWIDTH=8, CHANNELS=2).
// A reference model tracks the frame as "sub-frame index within the frame"
// plus the mode of that frame. cycle, plane and weight are derived from the
// index arithmetically. Directed scenarios compare against hand-derived
// constants; a randomized run compares every output against the model.
// ---------------------------------------------------------------------------
module tb_display_color_modulator;

  localparam int W    = 8;
  localparam int CH   = 2;
  localparam int PW   = 3;
  localparam int PIXW = CH*3*W;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic            advance;
  logic            in_valid;
  logic [PIXW-1:0] in_pixel;
  logic            out_valid;
  logic [CH*3-1:0] out_rgb;
  logic [W-1:0]    cycle;
  logic [PW-1:0]   plane;
  logic [W-1:0]    weight;
  logic            wrap;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              m_idx  = 0;
  bit              m_mode = 1'b0;
  logic [CH*3-1:0] e_rgb  = '0;
  logic            e_valid = 1'b0;
  logic            e_wrap  = 1'b0;

  display_color_modulator #(.CYCLEWIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .advance(advance), .in_valid(in_valid),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_rgb(out_rgb),
    .cycle(cycle), .plane(plane), .weight(weight), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int exp_cycle();
    return m_mode ? 1 : m_idx + 1;
  endfunction

  function automatic int exp_plane();
    return m_mode ? m_idx : 0;
  endfunction

  function automatic int exp_weight();
    return m_mode ? (1 << m_idx) : 1;
  endfunction

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    logic [W-1:0] x;
    if (rst) begin
      e_rgb   = '0;
      e_valid = 1'b0;
      e_wrap  = 1'b0;
      m_idx   = 0;
      m_mode  = mode;
    end else begin
      if (in_valid) begin
        e_valid = 1'b1;
        for (int c = 0; c < CH; c++) begin
          for (int k = 0; k < 3; k++) begin
            x = in_pixel[(c*3 + k)*W +: W];
            if (m_mode) e_rgb[c*3 + k] = ((x >> m_idx) & 1) != 0;
            else        e_rgb[c*3 + k] = (int'(x) >= m_idx + 1);
          end
        end
      end else begin
        e_valid = 1'b0;
      end
      e_wrap = 1'b0;
      if (advance) begin
        m_idx++;
        if (m_idx == (m_mode ? W : (1 << W) - 1)) begin
          m_idx  = 0;
          e_wrap = 1'b1;
          m_mode = mode;
        end
      end
    end
  endtask

  // One clock: wait for the edge, update the model, then settle past it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic md);
    rst = 1'b1; mode = md; advance = 1'b0; in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [PIXW-1:0] rand_pixel();
    return PIXW'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; advance = 1'b1; in_valid = 1'b1;
    in_pixel = rand_pixel();
    step();
    step();
    checks += 6;
    if (out_rgb !== 6'b0)  begin errors++; $display("[TB] FAIL reset_rgb: got %b expected 000000", out_rgb); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    if (cycle !== 8'd1)    begin errors++; $display("[TB] FAIL reset_cycle: got %0d expected 1", cycle); end
    if (plane !== 3'd0)    begin errors++; $display("[TB] FAIL reset_plane: got %0d expected 0", plane); end
    if (weight !== 8'd1)   begin errors++; $display("[TB] FAIL reset_weight: got %0d expected 1", weight); end
    if (wrap !== 1'b0)     begin errors++; $display("[TB] FAIL reset_wrap: got %b expected 0", wrap); end
    rst = 1'b0; advance = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_pwm_compare();
    do_reset(1'b0);
    advance = 1'b1;
    repeat (127) step();
    advance = 1'b0;
    checks++;
    if (cycle !== 8'h80) begin errors++; $display("[TB] FAIL pwm_cycle80: got %0h expected 80", cycle); end
    in_pixel = {24'hFFFFFF, 8'h80, 8'h7F, 8'h00};
    in_valid = 1'b1;
    step();
    checks += 2;
    if (out_valid !== 1'b1)      begin errors++; $display("[TB] FAIL pwm_valid: got %b expected 1", out_valid); end
    if (out_rgb !== 6'b111_100)  begin errors++; $display("[TB] FAIL pwm_rgb: got %b expected 111100", out_rgb); end
    // Zero component at the lowest threshold must stay dark.
    do_reset(1'b0);
    in_pixel = rand_pixel();
    in_pixel[7:0] = 8'h00;
    in_valid = 1'b1;
    step();
    checks += 2;
    if (out_rgb[0] !== 1'b0) begin errors++; $display("[TB] FAIL pwm_zero_b: got %b expected 0", out_rgb[0]); end
    if (out_rgb !== e_rgb)   begin errors++; $display("[TB] FAIL pwm_c1_rgb: got %b expected %b", out_rgb, e_rgb); end
    in_valid = 1'b0;
  endtask

  task automatic test_pwm_wrap();
    do_reset(1'b0);
    advance = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      step();
      checks += 3;
      if (cycle !== W'((i == 255) ? 1 : i + 1)) begin
        errors++; $display("[TB] FAIL pwm_wrap_cycle@%0d: got %0d expected %0d", i, cycle, (i == 255) ? 1 : i + 1);
      end
      if (weight !== 8'd1) begin errors++; $display("[TB] FAIL pwm_wrap_weight@%0d: got %0d expected 1", i, weight); end
      if (wrap !== (i == 255)) begin errors++; $display("[TB] FAIL pwm_wrap_pulse@%0d: got %b expected %b", i, wrap, i == 255); end
    end
    advance = 1'b0;
    step();
    checks += 2;
    if (wrap !== 1'b0)  begin errors++; $display("[TB] FAIL pwm_wrap_clear: got %b expected 0", wrap); end
    if (cycle !== 8'd1) begin errors++; $display("[TB] FAIL pwm_wrap_hold: got %0d expected 1", cycle); end
  endtask

  task automatic test_bcm();
    int rbit[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    do_reset(1'b1);
    in_pixel = rand_pixel();
    in_pixel[23:16] = 8'hA5;
    in_valid = 1'b1;
    advance  = 1'b1;
    for (int p = 0; p < 8; p++) begin
      checks += 2;
      if (plane !== PW'(p))      begin errors++; $display("[TB] FAIL bcm_plane@%0d: got %0d expected %0d", p, plane, p); end
      if (weight !== W'(1 << p)) begin errors++; $display("[TB] FAIL bcm_weight@%0d: got %0d expected %0d", p, weight, 1 << p); end
      step();
      checks += 2;
      if (out_rgb[2] !== rbit[p][0]) begin errors++; $display("[TB] FAIL bcm_rbit@%0d: got %b expected %0d", p, out_rgb[2], rbit[p]); end
      if (wrap !== (p == 7))      begin errors++; $display("[TB] FAIL bcm_wrap@%0d: got %b expected %b", p, wrap, p == 7); end
    end
    checks += 3;
    if (plane !== 3'd0)  begin errors++; $display("[TB] FAIL bcm_end_plane: got %0d expected 0", plane); end
    if (weight !== 8'd1) begin errors++; $display("[TB] FAIL bcm_end_weight: got %0d expected 1", weight); end
    if (cycle !== 8'd1)  begin errors++; $display("[TB] FAIL bcm_cycle_held: got %0d expected 1", cycle); end
    advance = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_mode_switch();
    do_reset(1'b0);
    advance = 1'b1;
    repeat (9) step();
    checks++;
    if (cycle !== 8'd10) begin errors++; $display("[TB] FAIL switch_c10: got %0d expected 10", cycle); end
    mode = 1'b1;
    for (int i = 10; i <= 254; i++) begin
      step();
      checks += 3;
      if (cycle !== W'(i + 1)) begin errors++; $display("[TB] FAIL switch_cycle@%0d: got %0d expected %0d", i, cycle, i + 1); end
      if (plane !== 3'd0)      begin errors++; $display("[TB] FAIL switch_plane@%0d: got %0d expected 0", i, plane); end
      if (wrap !== 1'b0)       begin errors++; $display("[TB] FAIL switch_early_wrap@%0d: got %b expected 0", i, wrap); end
    end
    step();
    checks += 4;
    if (wrap !== 1'b1)   begin errors++; $display("[TB] FAIL switch_wrap: got %b expected 1", wrap); end
    if (plane !== 3'd0)  begin errors++; $display("[TB] FAIL switch_plane0: got %0d expected 0", plane); end
    if (weight !== 8'd1) begin errors++; $display("[TB] FAIL switch_weight: got %0d expected 1", weight); end
    if (cycle !== 8'd1)  begin errors++; $display("[TB] FAIL switch_cycle1: got %0d expected 1", cycle); end
    // 0xA4 has bit0 clear, while PWM at threshold 1 would light it.
    advance = 1'b0;
    in_pixel = rand_pixel();
    in_pixel[23:16] = 8'hA4;
    in_valid = 1'b1;
    step();
    checks += 2;
    if (out_rgb[2] !== 1'b0) begin errors++; $display("[TB] FAIL switch_bcm_rbit: got %b expected 0", out_rgb[2]); end
    if (out_rgb !== e_rgb)   begin errors++; $display("[TB] FAIL switch_bcm_rgb: got %b expected %b", out_rgb, e_rgb); end
    in_valid = 1'b0;
    advance  = 1'b1;
    step();
    checks += 2;
    if (plane !== 3'd1)  begin errors++; $display("[TB] FAIL switch_plane1: got %0d expected 1", plane); end
    if (weight !== 8'd2) begin errors++; $display("[TB] FAIL switch_weight2: got %0d expected 2", weight); end
    advance = 1'b0;
    mode    = 1'b0;
  endtask

  task automatic test_simultaneous_abort();
    do_reset(1'b0);
    advance = 1'b1;
    repeat (4) step();
    checks++;
    if (cycle !== 8'd5) begin errors++; $display("[TB] FAIL simul_c5: got %0d expected 5", cycle); end
    in_pixel = rand_pixel();
    in_pixel[23:16] = 8'd5;
    in_valid = 1'b1;
    step();
    checks += 2;
    if (out_rgb[2] !== 1'b1) begin errors++; $display("[TB] FAIL simul_rbit: got %b expected 1", out_rgb[2]); end
    if (cycle !== 8'd6)      begin errors++; $display("[TB] FAIL simul_c6: got %0d expected 6", cycle); end
    in_valid = 1'b0;
    repeat (93) step();
    in_valid = 1'b1;
    step();
    checks += 2;
    if (cycle !== 8'd100)   begin errors++; $display("[TB] FAIL abort_c100: got %0d expected 100", cycle); end
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre_valid: got %b expected 1", out_valid); end
    rst = 1'b1;
    step();
    checks += 3;
    if (cycle !== 8'd1)     begin errors++; $display("[TB] FAIL abort_cycle: got %0d expected 1", cycle); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b expected 0", out_valid); end
    if (wrap !== 1'b0)      begin errors++; $display("[TB] FAIL abort_wrap: got %b expected 0", wrap); end
    rst = 1'b0; advance = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset(1'($urandom_range(0, 1)));
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      advance  = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_pixel = rand_pixel();
      step();
      checks++;
      if (out_rgb !== e_rgb || out_valid !== e_valid || wrap !== e_wrap ||
          cycle !== W'(exp_cycle()) || plane !== PW'(exp_plane()) || weight !== W'(exp_weight())) begin
        errors++;
        $display("[TB] FAIL random@%0d: got rgb=%b v=%b wrap=%b cyc=%0d pl=%0d wt=%0d expected rgb=%b v=%b wrap=%b cyc=%0d pl=%0d wt=%0d",
                 n, out_rgb, out_valid, wrap, cycle, plane, weight,
                 e_rgb, e_valid, e_wrap, exp_cycle(), exp_plane(), exp_weight());
      end
    end
    rst = 1'b0; advance = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; advance = 1'b0; in_valid = 1'b0; in_pixel = '0;
    test_reset();
    test_pwm_compare();
    test_pwm_wrap();
    test_bcm();
    test_mode_switch();
    test_simultaneous_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
